rx_uart_frame_tx: RTL
=====================

# rx_uart_frame_tx

Frame-aware UART egress stage for the receive path: buffers demapped payload bytes, releases them to a built-in UART serializer only after the frame is committed, and rolls back uncommitted bytes on a CRC-error drop instead of resetting the whole buffer. Sits between the demapper (payload + CRC verdict) and the board UART TX pin. It replaces the separate FIFO + fixed-rate serializer with one parametrised block: configurable width, depth, bit rate, parity and stop bits.

## Interface
- DATA_W, 8, payload bits per UART character (5..9)
- DEPTH, 64, buffer entries; power of 2, >= 4
- CLKS_PER_BIT, 868, i_clk cycles per UART bit (>= 2)
- PARITY, 0, 0 none / 1 even / 2 odd
- STOP_BITS, 1, 1 or 2
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_data  in  DATA_W  payload byte
- i_data_valid  in  1  byte offered
- o_data_ready  out  1  byte accepted when valid & ready
- i_frame_commit  in  1  pulse: all bytes written so far (incl. this cycle) become sendable
- i_frame_drop  in  1  pulse: discard all uncommitted bytes (incl. this cycle)
- i_tx_enable  in  1  allow new characters to start
- o_uart_tx  out  1  serial line, idle high
- o_busy  out  1  serializer not IDLE
- o_fill  out  log2(DEPTH)+1  entries held (committed + uncommitted)
- o_overflow  out  1  one-cycle pulse when an oversized frame is auto-dropped
- o_drop_count  out  8  frames dropped (explicit or auto), saturates at 255

## Operation
- Three pointers, log2(DEPTH)+1 bits, wrap modulo 2*DEPTH: wr_ptr, cm_ptr (commit), rd_ptr.
- Write: valid & ready & !discard -> mem[wr_ptr]=i_data, wr_ptr+1. o_data_ready = discard | (wr_ptr-rd_ptr != DEPTH).
- Commit: cm_ptr <= wr_ptr (+1 if write same cycle). Drop: wr_ptr <= cm_ptr; same-cycle write discarded; drop_count+1.
- Commit and drop same cycle: drop wins.
- Oversize: buffer full and cm_ptr==rd_ptr -> wr_ptr <= cm_ptr, o_overflow pulse, drop_count+1, enter discard. In discard, ready=1, bytes swallowed; next commit or drop clears discard, commits nothing, no further count increment.
- o_fill = wr_ptr - rd_ptr. Reader only sees rd_ptr != cm_ptr.
- Serializer FSM: IDLE, START, DATA, PAR, STOP. Pop condition = rd_ptr != cm_ptr & i_tx_enable.
  - IDLE: on pop, load shifter with mem[rd_ptr], rd_ptr+1, -> START.
  - START: line 0 for CLKS_PER_BIT cycles -> DATA.
  - DATA: DATA_W bits LSB first, CLKS_PER_BIT each -> PAR if PARITY!=0 else STOP.
  - PAR: even/odd parity over DATA_W bits -> STOP.
  - STOP: line 1 for STOP_BITS*CLKS_PER_BIT; at last cycle, if pop condition, pop and -> START (no gap), else -> IDLE.
- i_tx_enable low never aborts a character in flight; it only blocks the next pop.
- Drop never affects committed bytes or the character in flight.

## Timing
- Reset: o_uart_tx=1, o_busy=0, o_fill=0, o_overflow=0, o_drop_count=0, all pointers 0, discard=0, FSM IDLE, o_data_ready=1.
- Commit-to-line latency from IDLE: commit in cycle N -> pop in N+1 -> start bit on o_uart_tx from N+2.
- Character length: (1+DATA_W+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles; back-to-back characters with zero idle cycles.
- o_fill reflects writes/pops/drops one cycle after the event (registered pointers).
- o_data_ready is combinational from registered pointers and discard flag; no dependency on i_data_valid.
- Reset mid-character: line returns to 1 the next cycle; buffered data lost.

## Test plan
- CLKS_PER_BIT=4, DATA_W=8, PARITY=0: write 0xA5, commit -> line from N+2: 0, 1,0,1,0,0,1,0,1, 1, each 4 cycles; o_busy high 40 cycles.
- Write 3 bytes, drop, write 0x11, commit -> only 0x11 transmitted; o_drop_count=1; o_fill=0 after sending.
- Commit+drop same cycle with concurrent write, after 2 committed bytes -> 2 bytes sent, third discarded, count=1.
- DEPTH=4, write 5 bytes no commit -> o_overflow at full, next bytes swallowed with ready=1, commit clears discard, nothing sent, count=1.
- PARITY=2, two committed bytes 0x00/0xFF, i_tx_enable low until cycle 20 -> line idle until enable; parity bits 1 then 1 (odd); second start bit immediately after first stop.
- Assert i_rst during DATA bit 3 -> o_uart_tx=1, o_fill=0, FSM IDLE next cycle; subsequent commit sends normally.

Source files
------------

// File: rtl/rx_uart_frame_tx.sv
// Frame-aware UART egress: buffers payload, releases committed frames to a built-in
// serializer, and rolls back uncommitted bytes on drop or oversize.
module rx_uart_frame_tx #(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 64,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [DATA_W-1:0]        i_data,
  input  logic                     i_data_valid,
  output logic                     o_data_ready,
  input  logic                     i_frame_commit,
  input  logic                     i_frame_drop,
  input  logic                     i_tx_enable,
  output logic                     o_uart_tx,
  output logic                     o_busy,
  output logic [$clog2(DEPTH):0]   o_fill,
  output logic                     o_overflow,
  output logic [7:0]               o_drop_count
);

  // state  | meaning
  // IDLE   | line high, waiting for a committed byte and tx enable
  // START  | start bit (0)
  // DATA   | payload bits, LSB first
  // PAR    | parity bit (skipped when PARITY==0)
  // STOP   | stop bit(s); may pop the next byte on its last cycle

  localparam int AW        = $clog2(DEPTH);
  localparam int PW        = AW + 1;
  localparam int STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
  localparam int CW        = (STOP_CLKS > 2) ? $clog2(STOP_CLKS) : 1;
  localparam int BW        = $clog2(DATA_W);
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic          PAR_ODD = (PARITY == 2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr, r_cm_ptr, r_rd_ptr;
  logic              r_discard;
  logic [7:0]        r_drop_cnt;

  state_t            r_state, w_next;
  logic [CW-1:0]     r_cnt;
  logic [BW-1:0]     r_bit;
  logic [DATA_W-1:0] r_shift;
  logic              r_par;

  logic [PW-1:0]     w_used;
  logic              w_full, w_overflow, w_wr, w_pop_cond, w_pop, w_cnt_tc;
  logic [DATA_W-1:0] w_rd_data;

  assign w_used       = r_wr_ptr - r_rd_ptr;
  assign w_full       = (w_used == DEPTH_P);
  assign o_data_ready = r_discard | ~w_full;
  // A full buffer with nothing committed can never drain: auto-drop the frame.
  assign w_overflow   = w_full & (r_cm_ptr == r_rd_ptr) & ~r_discard;
  assign w_wr         = i_data_valid & o_data_ready & ~r_discard;
  assign w_pop_cond   = (r_rd_ptr != r_cm_ptr) & i_tx_enable;
  assign w_rd_data    = r_mem[r_rd_ptr[AW-1:0]];
  assign w_cnt_tc     = (r_cnt == '0);

  assign o_fill       = w_used;
  assign o_overflow   = w_overflow;
  assign o_drop_count = r_drop_cnt;

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_cm_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_discard  <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_overflow) begin
        r_wr_ptr  <= r_cm_ptr;
        r_discard <= 1'b1;
        if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 1'b1;
      end else if (i_frame_drop) begin
        r_wr_ptr  <= r_cm_ptr;
        r_discard <= 1'b0;
        if (!r_discard && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 1'b1;
      end else begin
        if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (i_frame_commit) begin
          r_discard <= 1'b0;
          if (!r_discard) r_cm_ptr <= r_wr_ptr + PW'(w_wr);
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pop_cond) begin
          w_pop  = 1'b1;
          w_next = S_START;
        end
      end
      S_START: if (w_cnt_tc) w_next = S_DATA;
      S_DATA: begin
        if (w_cnt_tc && r_bit == BW'(DATA_W - 1))
          w_next = (PARITY != 0) ? S_PAR : S_STOP;
      end
      S_PAR: if (w_cnt_tc) w_next = S_STOP;
      S_STOP: begin
        if (w_cnt_tc) begin
          if (w_pop_cond) begin
            w_pop  = 1'b1;
            w_next = S_START;
          end else begin
            w_next = S_IDLE;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
    end else begin
      if (r_state != w_next) begin
        r_cnt <= (w_next == S_STOP) ? CW'(STOP_CLKS - 1) : CW'(CLKS_PER_BIT - 1);
        r_bit <= '0;
      end else if (!w_cnt_tc) begin
        r_cnt <= r_cnt - 1'b1;
      end else if (r_state == S_DATA) begin
        r_cnt <= CW'(CLKS_PER_BIT - 1);
        r_bit <= r_bit + 1'b1;
      end

      if (w_pop) begin
        r_shift <= w_rd_data;
        r_par   <= (^w_rd_data) ^ PAR_ODD;
      end else if (r_state == S_DATA && w_cnt_tc) begin
        r_shift <= r_shift >> 1;
      end
    end
  end

  always_comb begin
    o_busy    = (r_state != S_IDLE);
    o_uart_tx = 1'b1;
    case (r_state)
      S_START: o_uart_tx = 1'b0;
      S_DATA:  o_uart_tx = r_shift[0];
      S_PAR:   o_uart_tx = r_par;
      default: o_uart_tx = 1'b1;
    endcase
  end

endmodule
